// File: rtl/jtvigil_pkg.sv
// Shared constants for the jtvigil main-CPU bus mapper: I/O register offsets,
// I/O write groups and memory region tags.
package jtvigil_pkg;

  localparam logic [2:0] IO_LATCH   = 3'd0;
  localparam logic [2:0] IO_FLIP    = 3'd1;
  localparam logic [2:0] IO_BANK    = 3'd4;

  localparam logic [2:0] GRP_SCROLL = 3'd0;
  localparam logic [2:0] GRP_ENABLE = 3'd1;

  localparam logic [1:0] REG_BANKWIN = 2'b10;
  localparam logic [3:0] REG_RAM     = 4'hE;
  localparam logic [3:0] REG_SCR     = 4'hD;
  localparam logic [4:0] REG_PAL     = 5'b11001;
  localparam logic [4:0] REG_OBJ     = 5'b11000;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_CTRL,
    WR_SCROLL,
    WR_ENABLE
  } wr_grp_e;

  // Classify an I/O write by the low address byte.
  function automatic wr_grp_e decode_wr(input logic [7:0] a);
    wr_grp_e grp;
    if (a[7] == 1'b0) begin
      grp = WR_CTRL;
    end else begin
      case (a[6:4])
        GRP_SCROLL: grp = WR_SCROLL;
        GRP_ENABLE: grp = WR_ENABLE;
        default:    grp = WR_NONE;
      endcase
    end
    return grp;
  endfunction

endpackage

// File: rtl/jtvigil_irqgen.sv
// VBLANK interrupt generator: LVBL falling-edge detect, pause masking, and an
// acknowledge / timeout clear. The edge pulse is shared with the scroll commit.
module jtvigil_irqgen #(
  parameter int INT_TO = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic lvbl,
  input  logic pause_n,
  input  logic ack,
  output logic vb_fall,
  output logic irq
);

  localparam int CW = (INT_TO > 1) ? $clog2(INT_TO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INT_TO - 1);

  logic          lvbl_r;
  logic          irq_r;
  logic [CW-1:0] cnt_r;

  assign vb_fall = lvbl_r & ~lvbl;
  assign irq     = irq_r;

  // Edge history, interrupt flag and its self-clear counter; ack beats a new set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvbl_r <= 1'b0;
      irq_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else begin
      lvbl_r <= lvbl;
      if (ack) begin
        irq_r <= 1'b0;
        cnt_r <= {CW{1'b0}};
      end else if (vb_fall && pause_n) begin
        irq_r <= 1'b1;
        cnt_r <= {CW{1'b0}};
      end else if (irq_r) begin
        if ((INT_TO != 0) && (cnt_r == CNT_LAST)) begin
          irq_r <= 1'b0;
        end else begin
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/jtvigil_busmap.sv
// Z80 main-CPU bus mapper: memory/I-O decode, banked ROM address, control and
// double-buffered scroll registers, VBLANK IRQ and ROM wait.
module jtvigil_busmap
  import jtvigil_pkg::*;
#(
  parameter int BANKW     = 3,
  parameter int BANK_BASE = 'h8000,
  parameter int NSCR      = 2,
  parameter int SCRW      = 11,
  parameter int VBLATCH   = 1,
  parameter int INT_TO    = 512,
  localparam int AW       = 15 + BANKW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          A,
  input  logic                 mreq_n,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 m1_n,
  input  logic [7:0]           cpu_dout,
  input  logic                 LVBL,
  input  logic                 dip_pause,
  input  logic                 rom_ok,
  output logic [AW-1:0]        main_addr,
  output logic                 rom_cs,
  output logic                 ram_cs,
  output logic                 scr_cs,
  output logic                 pal_cs,
  output logic                 obj_cs,
  output logic [2:0]           in_sel,
  output logic                 io_rd,
  output logic                 wait_n,
  output logic                 int_n,
  output logic                 latch_wr,
  output logic [BANKW-1:0]     bank,
  output logic                 flip,
  output logic [NSCR*SCRW-1:0] scr_pos,
  output logic [NSCR-1:0]      scr_enb
);

  logic             wr_q_r, latch_r, flip_r;
  logic [BANKW-1:0] bank_r;
  logic [SCRW-1:0]  shadow_r [NSCR];
  logic [SCRW-1:0]  pos_r    [NSCR];
  logic [NSCR-1:0]  enb_r;
  logic             hi_pend_r;
  logic [2:0]       hi_chan_r;

  logic    mreq_s, io_wr_s, wr_stb_s, vb_fall_s, irq_s;
  wr_grp_e grp_s;
  logic [2:0] chan_s;

  assign mreq_s = ~mreq_n;
  assign rom_cs = mreq_s & (~A[15] | (A[15:14] == REG_BANKWIN));
  assign ram_cs = mreq_s & (A[15:12] == REG_RAM);
  assign scr_cs = mreq_s & (A[15:12] == REG_SCR);
  assign pal_cs = mreq_s & (A[15:11] == REG_PAL);
  assign obj_cs = mreq_s & (A[15:11] == REG_OBJ) & ~wr_n;

  assign io_rd  = ~iorq_n & ~rd_n & m1_n;
  assign in_sel = A[2:0];
  assign wait_n = ~(rom_cs & ~rom_ok & ~rd_n);

  // Only the first clock of an I/O write acts, however long the CPU holds it.
  assign io_wr_s  = ~iorq_n & ~wr_n;
  assign wr_stb_s = io_wr_s & ~wr_q_r;
  assign grp_s    = decode_wr(A[7:0]);
  assign chan_s   = A[3:1];

  // Fixed window below 32K, banked 16K window above it.
  always_comb begin
    main_addr = {AW{1'b0}};
    if (A[15] == 1'b0) begin
      main_addr = AW'(A[14:0]);
    end else begin
      main_addr = AW'({bank_r, A[13:0]}) + AW'(BANK_BASE);
    end
  end

  jtvigil_irqgen #(.INT_TO(INT_TO)) u_irqgen (
    .clk     (clk),
    .rst     (rst),
    .lvbl    (LVBL),
    .pause_n (dip_pause),
    .ack     (~iorq_n & ~m1_n),
    .vb_fall (vb_fall_s),
    .irq     (irq_s)
  );

  // Write-edge history and the control register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q_r  <= 1'b0;
      latch_r <= 1'b0;
      flip_r  <= 1'b0;
      bank_r  <= {BANKW{1'b0}};
    end else begin
      wr_q_r  <= io_wr_s;
      latch_r <= wr_stb_s && (grp_s == WR_CTRL) && (A[2:0] == IO_LATCH);
      if (wr_stb_s && (grp_s == WR_CTRL)) begin
        case (A[2:0])
          IO_FLIP: flip_r <= cpu_dout[0];
          IO_BANK: bank_r <= cpu_dout[BANKW-1:0];
          default: flip_r <= flip_r;
        endcase
      end
    end
  end

  // Scroll shadows, committed positions and channel enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSCR; k++) begin
        shadow_r[k] <= {SCRW{1'b0}};
        pos_r[k]    <= {SCRW{1'b0}};
      end
      enb_r     <= {NSCR{1'b0}};
      hi_pend_r <= 1'b0;
      hi_chan_r <= 3'd0;
    end else begin
      hi_pend_r <= wr_stb_s && (grp_s == WR_SCROLL) && A[0];
      hi_chan_r <= chan_s;
      for (int k = 0; k < NSCR; k++) begin
        if (wr_stb_s && (grp_s == WR_SCROLL) && (chan_s == 3'(k))) begin
          if (A[0]) shadow_r[k][SCRW-1:8] <= cpu_dout[SCRW-9:0];
          else      shadow_r[k][7:0]      <= cpu_dout;
        end
        if (VBLATCH != 0) begin
          if (vb_fall_s) pos_r[k] <= shadow_r[k];
        end else if (hi_pend_r && (hi_chan_r == 3'(k))) begin
          pos_r[k] <= shadow_r[k];
        end
        if (wr_stb_s && (grp_s == WR_ENABLE) && (A[2:0] == 3'(k))) begin
          enb_r[k] <= cpu_dout[6];
        end
      end
    end
  end

  // Flatten committed positions, channel k at [k*SCRW +: SCRW].
  always_comb begin
    scr_pos = {(NSCR*SCRW){1'b0}};
    for (int k = 0; k < NSCR; k++) begin
      scr_pos[k*SCRW +: SCRW] = pos_r[k];
    end
  end

  assign latch_wr = latch_r;
  assign flip     = flip_r;
  assign bank     = bank_r;
  assign scr_enb  = enb_r;
  assign int_n    = ~irq_s;

endmodule

// File: tb/tb_jtvigil_busmap.sv
// Scoreboard bench for jtvigil_busmap: stimulus queues expected output values
// tagged with a cycle, a negedge monitor pops and compares them.
module tb_jtvigil_busmap;

  localparam int BANKW = 3;
  localparam int NSCR  = 2;
  localparam int SCRW  = 11;
  localparam int INT_TO = 512;
  localparam int AW    = 15 + BANKW;

  localparam int S_MAIN = 0, S_ROM = 1, S_RAM = 2, S_SCR = 3, S_PAL = 4, S_OBJ = 5;
  localparam int S_INSEL = 6, S_IORD = 7, S_WAIT = 8, S_INT = 9, S_LATCH = 10;
  localparam int S_BANK = 11, S_FLIP = 12, S_POS = 13, S_ENB = 14;

  logic clk = 1'b0, rst;
  logic [15:0] A;
  logic mreq_n, iorq_n, rd_n, wr_n, m1_n, LVBL, dip_pause, rom_ok;
  logic [7:0] cpu_dout;
  logic [AW-1:0] main_addr;
  logic rom_cs, ram_cs, scr_cs, pal_cs, obj_cs, io_rd, wait_n, int_n, latch_wr, flip;
  logic [2:0] in_sel;
  logic [BANKW-1:0] bank;
  logic [NSCR*SCRW-1:0] scr_pos;
  logic [NSCR-1:0] scr_enb;

  jtvigil_busmap dut (
    .clk(clk), .rst(rst), .A(A), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .m1_n(m1_n), .cpu_dout(cpu_dout), .LVBL(LVBL), .dip_pause(dip_pause),
    .rom_ok(rom_ok), .main_addr(main_addr), .rom_cs(rom_cs), .ram_cs(ram_cs),
    .scr_cs(scr_cs), .pal_cs(pal_cs), .obj_cs(obj_cs), .in_sel(in_sel), .io_rd(io_rd),
    .wait_n(wait_n), .int_n(int_n), .latch_wr(latch_wr), .bank(bank), .flip(flip),
    .scr_pos(scr_pos), .scr_enb(scr_enb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_MAIN:  return 32'(main_addr);
      S_ROM:   return 32'(rom_cs);
      S_RAM:   return 32'(ram_cs);
      S_SCR:   return 32'(scr_cs);
      S_PAL:   return 32'(pal_cs);
      S_OBJ:   return 32'(obj_cs);
      S_INSEL: return 32'(in_sel);
      S_IORD:  return 32'(io_rd);
      S_WAIT:  return 32'(wait_n);
      S_INT:   return 32'(int_n);
      S_LATCH: return 32'(latch_wr);
      S_BANK:  return 32'(bank);
      S_FLIP:  return 32'(flip);
      S_POS:   return 32'(scr_pos);
      S_ENB:   return 32'(scr_enb);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
      e   = sb_q.pop_front();
      act = actual(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, act, e.exp, cycle);
      end
    end
  end

  task automatic push_exp(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cycle; e.sel = sel; e.exp = v; e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    A = a; cpu_dout = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (hold) tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; A = 16'h0000; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m1_n = 1'b1; cpu_dout = 8'h00; LVBL = 1'b1; dip_pause = 1'b1; rom_ok = 1'b1;
    tick();
    push_exp("rst_int_n", S_INT, 32'd1);   push_exp("rst_wait_n", S_WAIT, 32'd1);
    push_exp("rst_latch", S_LATCH, 32'd0); push_exp("rst_bank", S_BANK, 32'd0);
    push_exp("rst_flip", S_FLIP, 32'd0);   push_exp("rst_pos", S_POS, 32'd0);
    push_exp("rst_enb", S_ENB, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Bank and memory decode
    io_write(16'h0004, 8'h05, 2);
    push_exp("bank", S_BANK, 32'd5);
    A = 16'h8123; mreq_n = 1'b0; rd_n = 1'b0;
    push_exp("main_banked", S_MAIN, 32'h1C123); push_exp("rom_cs_hi", S_ROM, 32'd1);
    push_exp("wait_ok", S_WAIT, 32'd1);
    tick();
    A = 16'h1234;
    push_exp("main_fixed", S_MAIN, 32'h01234); push_exp("rom_cs_lo", S_ROM, 32'd1);
    tick();
    A = 16'hE000;
    push_exp("ram_cs", S_RAM, 32'd1); push_exp("ram_not_rom", S_ROM, 32'd0);
    tick();
    A = 16'hD000; push_exp("scr_cs", S_SCR, 32'd1); tick();
    A = 16'hC800; push_exp("pal_cs", S_PAL, 32'd1); push_exp("pal_not_obj", S_OBJ, 32'd0); tick();
    A = 16'hC000; push_exp("obj_rd", S_OBJ, 32'd0); tick();
    rd_n = 1'b1; wr_n = 1'b0; push_exp("obj_wr", S_OBJ, 32'd1); tick();
    wr_n = 1'b1; mreq_n = 1'b1; A = 16'h8123; push_exp("rom_no_mreq", S_ROM, 32'd0); tick();

    // Scroll channel 0, long write acts once
    io_write(16'h0080, 8'h34, 1);
    A = 16'h0081; cpu_dout = 8'h05; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    cpu_dout = 8'h07;
    repeat (5) tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();
    push_exp("pos_before_vbl", S_POS, 32'd0);
    tick();
    LVBL = 1'b0;
    push_exp("pos_at_fall", S_POS, 32'd0); push_exp("int_before", S_INT, 32'd1);
    tick();
    push_exp("pos_commit0", S_POS, 32'h534); push_exp("int_set", S_INT, 32'd0);
    repeat (8) tick();
    push_exp("int_held", S_INT, 32'd0);
    iorq_n = 1'b0; m1_n = 1'b0;
    tick();
    iorq_n = 1'b1; m1_n = 1'b1;
    push_exp("int_ack", S_INT, 32'd1);
    tick();
    LVBL = 1'b1;
    tick();

    // Channel 1, ignored channel 3, enables
    io_write(16'h0082, 8'hAB, 1);
    io_write(16'h0083, 8'h03, 1);
    io_write(16'h0086, 8'hFF, 1);
    io_write(16'h0087, 8'hFF, 1);
    io_write(16'h0090, 8'h40, 1); push_exp("enb0", S_ENB, 32'd1);
    io_write(16'h0091, 8'h40, 1); push_exp("enb01", S_ENB, 32'd3);
    io_write(16'h0092, 8'h40, 1); push_exp("enb_ignored", S_ENB, 32'd3);
    io_write(16'h0091, 8'h00, 1); push_exp("enb1_off", S_ENB, 32'd1);
    push_exp("pos_no_commit", S_POS, 32'h534);
    tick();

    // Paused frames; shadow write coinciding with commit lands next frame
    dip_pause = 1'b0;
    LVBL = 1'b0; A = 16'h0080; cpu_dout = 8'h11; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    push_exp("pos_commit1", S_POS, 32'h1D5D34); push_exp("int_paused", S_INT, 32'd1);
    tick();
    LVBL = 1'b1;
    repeat (2) tick();
    LVBL = 1'b0;
    tick();
    push_exp("pos_commit2", S_POS, 32'h1D5D11); push_exp("int_paused2", S_INT, 32'd1);
    tick();
    LVBL = 1'b1; dip_pause = 1'b1;
    tick();

    // IRQ timeout
    LVBL = 1'b0;
    tick();
    push_exp("int_to_set", S_INT, 32'd0);
    repeat (INT_TO - 1) tick();
    push_exp("int_to_last", S_INT, 32'd0);
    tick();
    push_exp("int_to_clear", S_INT, 32'd1);
    LVBL = 1'b1;
    tick();

    // ROM wait
    A = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0; rom_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp("wait_low", S_WAIT, 32'd0);
      tick();
    end
    rom_ok = 1'b1; push_exp("wait_release", S_WAIT, 32'd1); tick();
    rom_ok = 1'b0; A = 16'hE000; push_exp("wait_ram", S_WAIT, 32'd1); tick();
    A = 16'h0100; mreq_n = 1'b1; push_exp("wait_no_cs", S_WAIT, 32'd1); tick();
    rd_n = 1'b1; rom_ok = 1'b1;

    // I/O read
    A = 16'h0005; iorq_n = 1'b0; rd_n = 1'b0;
    push_exp("io_rd", S_IORD, 32'd1); push_exp("in_sel", S_INSEL, 32'd5);
    tick();
    m1_n = 1'b0; push_exp("io_rd_m1", S_IORD, 32'd0); tick();
    m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
    tick();

    // Sound latch pulse on a held write
    A = 16'h0000; cpu_dout = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    push_exp("latch_pre", S_LATCH, 32'd0);
    tick();
    push_exp("latch_pulse", S_LATCH, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      push_exp("latch_once", S_LATCH, 32'd0);
    end
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a write with IRQ pending
    io_write(16'h0001, 8'h01, 1);
    push_exp("flip_set", S_FLIP, 32'd1);
    LVBL = 1'b0;
    tick();
    push_exp("int_pre_rst", S_INT, 32'd0);
    LVBL = 1'b1;
    tick();
    A = 16'h0000; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    push_exp("arst_latch", S_LATCH, 32'd0); push_exp("arst_flip", S_FLIP, 32'd0);
    push_exp("arst_bank", S_BANK, 32'd0);   push_exp("arst_int", S_INT, 32'd1);
    push_exp("arst_pos", S_POS, 32'd0);     push_exp("arst_enb", S_ENB, 32'd0);
    push_exp("arst_main", S_MAIN, 32'd0);
    tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push_exp("post_rst_latch", S_LATCH, 32'd0);
    tick();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
